// File: rtl/cv32e40p_x_copro_pkg.sv
// Shared types for the custom-0 coprocessor: opcode, funct3 encodings,
// pending-queue entry layout and the ALU function used at result time.
package cv32e40p_x_copro_pkg;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

    typedef enum logic [2:0] {
        F3_ADD3 = 3'b000,
        F3_MADD = 3'b001,
        F3_MAXS = 3'b010
    } funct3_e;

    typedef struct packed {
        logic [3:0]       id;
        logic [4:0]       rd;
        funct3_e          f3;
        logic [2:0][31:0] rs;         // rs[0] = rs1
        logic             committed;
        logic             killed;
    } q_entry_t;

    // All arithmetic wraps at 32 bits; MADD keeps only the low product word.
    function automatic logic [31:0] copro_alu(input funct3_e f3, input logic [2:0][31:0] rs);
        logic [31:0] res;
        case (f3)
            F3_ADD3: res = rs[0] + rs[1] + rs[2];
            F3_MADD: res = (rs[0] * rs[1]) + rs[2];
            F3_MAXS: res = ($signed(rs[0]) > $signed(rs[1])) ? rs[0] : rs[1];
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cv32e40p_x_copro_queue.sv
// Circular pending-instruction queue. Entries are marked committed/killed by
// id; a commit that matches nothing queued may mark the entry being pushed.
module cv32e40p_x_copro_queue
    import cv32e40p_x_copro_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_push,
    input  q_entry_t   i_push_entry,
    input  logic       i_pop,
    input  logic       i_cmt_valid,
    input  logic [3:0] i_cmt_id,
    input  logic       i_cmt_kill,
    output logic       o_full,
    output logic       o_empty,
    output q_entry_t   o_head
);

    localparam int AW = $clog2(DEPTH);

    q_entry_t         r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_cnt;

    logic [DEPTH-1:0] w_mark;
    logic             w_mark_push;
    q_entry_t         w_push_entry;

    // Id match against live, still-unmarked entries; repeats are ignored.
    always_comb begin
        w_mark = '0;
        for (int i = 0; i < DEPTH; i++)
            w_mark[i] = i_cmt_valid && r_vld[i] && (r_mem[i].id == i_cmt_id)
                        && !r_mem[i].committed && !r_mem[i].killed;
    end

    // Same-cycle commit of the incoming entry, only when no queued entry matched.
    always_comb begin
        w_mark_push  = i_cmt_valid && !(|w_mark) && (i_push_entry.id == i_cmt_id);
        w_push_entry = i_push_entry;
        if (w_mark_push) begin
            if (i_cmt_kill) w_push_entry.killed    = 1'b1;
            else            w_push_entry.committed = 1'b1;
        end
    end

    // Entry storage: payload needs no reset, validity lives in r_vld.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_mark[i]) begin
                if (i_cmt_kill) r_mem[i].killed    <= 1'b1;
                else            r_mem[i].committed <= 1'b1;
            end
        end
        if (i_push) r_mem[r_wptr] <= w_push_entry;
    end

    // Pointers, occupancy and per-slot valid bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            if (i_push) begin
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/cv32e40p_x_copro_ctrl.sv
// XIF coprocessor responder: decodes custom-0 issues, queues them until
// commit, executes one at a time in order and returns results.
module cv32e40p_x_copro_ctrl
    import cv32e40p_x_copro_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             x_issue_valid_i,
    output logic             x_issue_ready_o,
    input  logic [31:0]      x_issue_req_instr_i,
    input  logic [3:0]       x_issue_req_id_i,
    input  logic [2:0][31:0] x_issue_req_rs_i,
    input  logic [2:0]       x_issue_req_rs_valid_i,
    output logic             x_issue_resp_accept_o,
    output logic             x_issue_resp_writeback_o,
    output logic             x_issue_resp_loadstore_o,
    input  logic             x_commit_valid_i,
    input  logic [3:0]       x_commit_id_i,
    input  logic             x_commit_kill_i,
    output logic             x_result_valid_o,
    input  logic             x_result_ready_i,
    output logic [3:0]       x_result_id_o,
    output logic [4:0]       x_result_rd_o,
    output logic [31:0]      x_result_data_o,
    output logic             x_result_we_o
);

    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    state_e           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_id, r_res_id;
    logic [4:0]       r_rd, r_res_rd;
    funct3_e          r_f3;
    logic [2:0][31:0] r_rs;
    logic [31:0]      r_res_data;

    funct3_e          w_f3, w_src_f3;
    logic             w_accept, w_rs_ok, w_push, w_full, w_empty;
    logic             w_start, w_load, w_pop;
    q_entry_t         w_new, w_head;
    logic [2:0][31:0] w_src_rs;
    logic [3:0]       w_src_id;
    logic [4:0]       w_src_rd;
    logic [31:0]      w_alu;
    logic             w_unused_instr;

    // Decode and issue handshake; rejected opcodes always handshake.
    assign w_f3     = funct3_e'(x_issue_req_instr_i[14:12]);
    assign w_accept = (x_issue_req_instr_i[6:0] == OPCODE_CUSTOM0) &&
                      (w_f3 == F3_ADD3 || w_f3 == F3_MADD || w_f3 == F3_MAXS);
    assign w_rs_ok  = (w_f3 == F3_MAXS) ? &x_issue_req_rs_valid_i[1:0]
                                        : &x_issue_req_rs_valid_i;
    assign x_issue_ready_o          = !w_accept || (!w_full && w_rs_ok);
    assign x_issue_resp_accept_o    = w_accept;
    assign x_issue_resp_writeback_o = w_accept;
    assign x_issue_resp_loadstore_o = 1'b0;
    assign w_push = x_issue_valid_i && x_issue_ready_o && w_accept;
    assign w_unused_instr = ^x_issue_req_instr_i[31:15];

    // Build the queue entry for an accepted issue.
    always_comb begin
        w_new           = '0;
        w_new.id        = x_issue_req_id_i;
        w_new.rd        = x_issue_req_instr_i[11:7];
        w_new.f3        = w_f3;
        w_new.rs        = x_issue_req_rs_i;
    end

    cv32e40p_x_copro_queue #(.DEPTH(DEPTH)) u_queue (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_push       (w_push),
        .i_push_entry (w_new),
        .i_pop        (w_pop),
        .i_cmt_valid  (x_commit_valid_i),
        .i_cmt_id     (x_commit_id_i),
        .i_cmt_kill   (x_commit_kill_i),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head       (w_head)
    );

    // With LATENCY==1 the result is computed straight from the queue head.
    assign w_src_f3 = (r_state == S_IDLE) ? w_head.f3 : r_f3;
    assign w_src_rs = (r_state == S_IDLE) ? w_head.rs : r_rs;
    assign w_src_id = (r_state == S_IDLE) ? w_head.id : r_id;
    assign w_src_rd = (r_state == S_IDLE) ? w_head.rd : r_rd;
    assign w_alu    = copro_alu(w_src_f3, w_src_rs);

    // Executor next-state: drop killed heads, start committed ones, drain result.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_load  = 1'b0;
        w_pop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head.killed) begin
                        w_pop = 1'b1;
                    end else if (w_head.committed) begin
                        w_start = 1'b1;
                        if (LATENCY == 1) begin
                            w_load = 1'b1;
                            w_next = S_RESP;
                        end else begin
                            w_next = S_EXEC;
                        end
                    end
                end
            end
            S_EXEC: begin
                if (r_cnt == CW'(1)) begin
                    w_load = 1'b1;
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (x_result_ready_i) begin
                    w_pop  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Executor state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Operand latch and latency counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_id  <= '0;
            r_rd  <= '0;
            r_f3  <= F3_ADD3;
            r_rs  <= '0;
        end else if (w_start) begin
            r_cnt <= CW'(LATENCY - 1);
            r_id  <= w_head.id;
            r_rd  <= w_head.rd;
            r_f3  <= w_head.f3;
            r_rs  <= w_head.rs;
        end else if (r_state == S_EXEC) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Result register, held until the core takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_res_id   <= '0;
            r_res_rd   <= '0;
            r_res_data <= '0;
        end else if (w_load) begin
            r_res_id   <= w_src_id;
            r_res_rd   <= w_src_rd;
            r_res_data <= w_alu;
        end
    end

    assign x_result_valid_o = (r_state == S_RESP);
    assign x_result_we_o    = (r_state == S_RESP);
    assign x_result_id_o    = r_res_id;
    assign x_result_rd_o    = r_res_rd;
    assign x_result_data_o  = r_res_data;

endmodule

// File: tb/tb_cv32e40p_x_copro_ctrl.sv
// Directed bench for the XIF coprocessor controller (DEPTH=4, LATENCY=2).
module tb_cv32e40p_x_copro_ctrl;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             iv, iready, acc, wb, ls;
    logic [31:0]      instr;
    logic [3:0]       iid;
    logic [2:0][31:0] rs;
    logic [2:0]       rsv;
    logic             cv, ck;
    logic [3:0]       cid;
    logic             rv, rr, rwe;
    logic [3:0]       rid;
    logic [4:0]       rrd;
    logic [31:0]      rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cv32e40p_x_copro_ctrl #(.DEPTH(4), .LATENCY(2)) dut (
        .clk_i                    (clk),
        .rst_ni                   (rst_n),
        .x_issue_valid_i          (iv),
        .x_issue_ready_o          (iready),
        .x_issue_req_instr_i      (instr),
        .x_issue_req_id_i         (iid),
        .x_issue_req_rs_i         (rs),
        .x_issue_req_rs_valid_i   (rsv),
        .x_issue_resp_accept_o    (acc),
        .x_issue_resp_writeback_o (wb),
        .x_issue_resp_loadstore_o (ls),
        .x_commit_valid_i         (cv),
        .x_commit_id_i            (cid),
        .x_commit_kill_i          (ck),
        .x_result_valid_o         (rv),
        .x_result_ready_i         (rr),
        .x_result_id_o            (rid),
        .x_result_rd_o            (rrd),
        .x_result_data_o          (rdata),
        .x_result_we_o            (rwe)
    );

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {17'd0, f3, rd, opc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drv_issue(input logic [31:0] ins, input logic [3:0] id,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] r3, input logic [2:0] v);
        iv = 1'b1; instr = ins; iid = id; rs[0] = r1; rs[1] = r2; rs[2] = r3; rsv = v;
    endtask

    task automatic drv_cmt(input logic v, input logic [3:0] id, input logic k);
        cv = v; cid = id; ck = k;
    endtask

    task automatic idle_in;
        iv = 1'b0; cv = 1'b0;
    endtask

    // Bounded wait for result_valid; n = negedges waited.
    task automatic wait_res(output bit got, output int n);
        got = 1'b0;
        n   = 0;
        for (int k = 0; k < 20; k++) begin
            if (rv) begin
                got = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    localparam logic [6:0] OPC = 7'b0001011;

    initial begin
        bit got;
        int n;
        int seen;
        rst_n = 1'b0; rr = 1'b1;
        iv = 0; instr = '0; iid = '0; rs = '0; rsv = '0; cv = 0; cid = '0; ck = 0;
        tick(); tick();
        // reset state
        chk("rst_valid", rv, 0);
        chk("rst_id", rid, 0);
        chk("rst_rd", rrd, 0);
        chk("rst_data", rdata, 0);
        chk("rst_we", rwe, 0);
        chk("rst_ready", iready, 1);
        rst_n = 1'b1;
        tick();

        // ADD3 id=3 with same-cycle commit: result at T+3
        drv_issue(mk(3'b000, 5'd5, OPC), 4'd3, 1, 2, 3, 3'b111);
        drv_cmt(1, 4'd3, 0);
        #1;
        chk("add3_ready", iready, 1);
        chk("add3_accept", acc, 1);
        chk("add3_wb", wb, 1);
        chk("add3_ls", ls, 0);
        tick(); idle_in();
        chk("add3_t1", rv, 0);
        tick();
        chk("add3_t2", rv, 0);
        tick();
        chk("add3_t3_valid", rv, 1);
        chk("add3_id", rid, 3);
        chk("add3_rd", rrd, 5);
        chk("add3_data", rdata, 6);
        chk("add3_we", rwe, 1);
        tick();
        chk("add3_onecycle", rv, 0);

        // rejected opcode: handshakes, never produces a result
        drv_issue(mk(3'b000, 5'd1, 7'b0110011), 4'd7, 9, 9, 9, 3'b000);
        drv_cmt(1, 4'd7, 0);
        #1;
        chk("rej_ready", iready, 1);
        chk("rej_accept", acc, 0);
        chk("rej_wb", wb, 0);
        tick(); idle_in();
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (rv) seen++;
            tick();
        end
        chk("rej_nores", seen, 0);

        // MADD waits for all operands
        drv_issue(mk(3'b001, 5'd6, OPC), 4'd4, 32'hFFFF_FFFF, 2, 5, 3'b011);
        #1;
        chk("madd_rsv011", iready, 0);
        tick();
        chk("madd_still0", iready, 0);
        rsv = 3'b111;
        drv_cmt(1, 4'd4, 0);
        #1;
        chk("madd_rsv111", iready, 1);
        tick(); idle_in();
        wait_res(got, n);
        chk("madd_got", got, 1);
        chk("madd_id", rid, 4);
        chk("madd_data", rdata, 32'h0000_0003);
        tick();

        // killed id=1 produces nothing; following id=2 returns normally
        drv_issue(mk(3'b000, 5'd7, OPC), 4'd1, 10, 20, 30, 3'b111);
        tick(); idle_in();
        drv_cmt(1, 4'd1, 1);
        tick();
        drv_cmt(0, 4'd0, 0);
        drv_issue(mk(3'b000, 5'd8, OPC), 4'd2, 7, 8, 9, 3'b111);
        drv_cmt(1, 4'd2, 0);
        tick(); idle_in();
        wait_res(got, n);
        chk("kill_got", got, 1);
        chk("kill_next_id", rid, 2);
        chk("kill_next_data", rdata, 24);
        tick();

        // fill the queue with uncommitted entries
        drv_issue(mk(3'b010, 5'd9, OPC), 4'd8, 32'hFFFF_FFFB, 3, 0, 3'b011);
        #1; chk("fill0_ready", iready, 1);
        tick();
        drv_issue(mk(3'b010, 5'd10, OPC), 4'd9, 7, 32'h8000_0000, 0, 3'b011);
        #1; chk("fill1_ready", iready, 1);
        tick();
        drv_issue(mk(3'b010, 5'd11, OPC), 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 3'b011);
        #1; chk("fill2_ready", iready, 1);
        tick();
        drv_issue(mk(3'b000, 5'd12, OPC), 4'd11, 1, 1, 1, 3'b111);
        #1; chk("fill3_ready", iready, 1);
        tick();
        drv_issue(mk(3'b000, 5'd13, OPC), 4'd12, 1, 1, 1, 3'b111);
        #1;
        chk("full_ready", iready, 0);
        chk("full_accept", acc, 1);
        drv_issue(mk(3'b000, 5'd1, 7'b0110011), 4'd12, 0, 0, 0, 3'b000);
        #1;
        chk("full_rej_ready", iready, 1);
        tick();
        drv_issue(mk(3'b000, 5'd13, OPC), 4'd12, 1, 1, 1, 3'b111);
        #1;
        chk("full_still", iready, 0);
        idle_in();
        // commit in reverse order so the head is marked last
        drv_cmt(1, 4'd11, 0); tick();
        drv_cmt(1, 4'd10, 0); tick();
        drv_cmt(1, 4'd9, 0);  tick();
        drv_cmt(1, 4'd8, 0);  tick();
        drv_cmt(0, 4'd0, 0);
        wait_res(got, n);
        chk("q0_got", got, 1);
        chk("q0_id", rid, 8);
        chk("q0_data", rdata, 3);
        // full queue with a pop this cycle: still not ready
        drv_issue(mk(3'b000, 5'd13, OPC), 4'd13, 1, 1, 1, 3'b111);
        #1;
        chk("full_pop_ready", iready, 0);
        iv = 1'b0;
        tick();
        wait_res(got, n);
        chk("q1_got", got, 1);
        chk("q1_gap", n, 2);
        chk("q1_id", rid, 9);
        chk("q1_data", rdata, 7);
        tick();
        wait_res(got, n);
        chk("q2_got", got, 1);
        chk("q2_gap", n, 2);
        chk("q2_id", rid, 10);
        chk("q2_data", rdata, 32'hFFFF_FFFF);
        tick();
        wait_res(got, n);
        chk("q3_got", got, 1);
        chk("q3_gap", n, 2);
        chk("q3_id", rid, 11);
        chk("q3_data", rdata, 3);
        tick();

        // back-pressure: result held stable while ready is low
        rr = 1'b0;
        drv_issue(mk(3'b000, 5'd14, OPC), 4'd5, 100, 200, 300, 3'b111);
        drv_cmt(1, 4'd5, 0);
        tick(); idle_in();
        wait_res(got, n);
        chk("stall_got", got, 1);
        chk("stall_data0", rdata, 600);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_valid", rv, 1);
            chk("stall_id", rid, 5);
            chk("stall_rd", rrd, 14);
            chk("stall_data", rdata, 600);
        end
        rr = 1'b1;
        tick();
        chk("stall_popped", rv, 0);

        // kill aimed at an already-committed, executing entry is ignored
        drv_issue(mk(3'b000, 5'd15, OPC), 4'd6, 1, 2, 3, 3'b111);
        drv_cmt(1, 4'd6, 0);
        tick(); iv = 1'b0;
        drv_cmt(1, 4'd6, 1);
        tick(); idle_in();
        wait_res(got, n);
        chk("latekill_got", got, 1);
        chk("latekill_id", rid, 6);
        chk("latekill_data", rdata, 6);
        tick();

        // reset mid-execution discards the in-flight instruction
        drv_issue(mk(3'b000, 5'd16, OPC), 4'd14, 4, 5, 6, 3'b111);
        drv_cmt(1, 4'd14, 0);
        tick(); idle_in();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", rv, 0);
        chk("midrst_data", rdata, 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rv) seen++;
        end
        chk("midrst_nores", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40p_x_copro_ctrl.md
# cv32e40p_x_copro_ctrl

Coprocessor-side controller for the CORE-V-XIF offload interface: the responder that receives issue requests from the cv32e40p dispatcher, decides accept/writeback/loadstore, tracks commit/kill per instruction id, executes a small custom-0 ALU operation set, and returns results on the result channel. It sits outside the core, connected directly to the core's x-interface ports. It never uses the memory channel.

## Interface
Parameters:
- DEPTH, 4: pending-instruction queue entries (power of two, ≥2).
- LATENCY, 2: execute cycles per instruction (≥1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- x_issue_valid_i  in  1  issue request valid.
- x_issue_ready_o  out  1  issue request ready.
- x_issue_req_instr_i  in  32  offloaded instruction word.
- x_issue_req_id_i  in  4  instruction id.
- x_issue_req_rs_i  in  3x32  source operand values rs1..rs3.
- x_issue_req_rs_valid_i  in  3  per-operand valid.
- x_issue_resp_accept_o  out  1  instruction accepted.
- x_issue_resp_writeback_o  out  1  instruction will write rd.
- x_issue_resp_loadstore_o  out  1  memory instruction; constant 0.
- x_commit_valid_i  in  1  commit transaction valid.
- x_commit_id_i  in  4  id being committed or killed.
- x_commit_kill_i  in  1  1 = kill, 0 = commit.
- x_result_valid_o  out  1  result valid.
- x_result_ready_i  in  1  core ready for result.
- x_result_id_o  out  4  id of result.
- x_result_rd_o  out  5  destination register.
- x_result_data_o  out  32  result value.
- x_result_we_o  out  1  register write enable; 1 whenever result valid.

## Operation
- Decode: accepted iff instr[6:0] = 7'b0001011 (custom-0) and funct3 (instr[14:12]) ∈ {000, 001, 010}. rd = instr[11:7], rs3 = instr[31:27].
  - 000 ADD3: rs1+rs2+rs3, mod 2^32.
  - 001 MADD: low 32 bits of rs1*rs2, plus rs3, mod 2^32.
  - 010 MAXS: signed max(rs1, rs2); rs3 unused.
- Operand need: ADD3/MADD need rs_valid[2:0] all set; MAXS needs [1:0].
- x_issue_ready_o (combinational) =
  - 1 for rejected instructions;
  - for accepted instructions: queue not full and all needed rs_valid set.
- Response outputs are meaningful only in the handshake cycle. accept = writeback = decode-accept; loadstore = 0. Rejected handshake enqueues nothing.
- Accepted handshake enqueues {id, rd, funct3, operands, committed=0, killed=0}.
- Commit: x_commit_valid_i marks the matching queued entry, or the entry enqueued in the same cycle.
  - kill=0 sets committed.
  - kill=1 sets killed.
  - Commits naming no valid entry are ignored.
  - A repeated commit of an already-marked entry is ignored.
- Execute: in-order, one instruction at a time, head of queue only.
  - Head killed: popped in 1 cycle, no result.
  - Head committed, not killed, executor idle: operands latched, LATENCY-cycle counter starts.
- Result: on counter expiry the result register is loaded and x_result_valid_o rises. It holds all fields stable until x_result_ready_i. On handshake the entry pops, and the next head may start the following cycle.

## Timing
- Reset values: x_result_valid_o, x_result_id_o, x_result_rd_o, x_result_data_o, x_result_we_o = 0; queue empty; counter 0. Combinational outputs follow from the empty state.
- Latency with accepted issue+commit in cycle T, executor idle, result ready held 1:
  - exec starts T+1;
  - x_result_valid_o high at T+1+LATENCY, for 1 cycle.
- Back-to-back throughput: one result per LATENCY+1 cycles.
- Full queue: ready = 0 for accepted opcodes; rejected opcodes still handshake.
- Queue full with pop in the same cycle: ready stays 0 (no pass-through).
- Simultaneous enqueue and pop: both take effect; pointers wrap mod DEPTH.
- Kill arriving for an entry already executing: ignored (entry is committed).
- Reset mid-operation: all state cleared; in-flight results discarded.

## Structure
- Package cv32e40p_x_copro_pkg:
  - OPCODE_CUSTOM0 constant;
  - funct3 enum (ADD3, MADD, MAXS);
  - queue-entry struct typedef.
- Sub-module cv32e40p_x_copro_queue: DEPTH-entry circular queue with id-match commit/kill marking, full/empty flags and head output.
- Execute counter and result register stay in the top module.

## Test plan
- Reset, then issue ADD3 id=3, rs=1/2/3, rs_valid=111, commit kill=0 same cycle:
  - handshake with accept=1, writeback=1, loadstore=0;
  - result id=3, data=6 at T+3 (LATENCY=2).
- Issue opcode 7'b0110011:
  - ready=1, accept=0, writeback=0;
  - no result ever.
- MADD with rs_valid=011: ready=0 until rs_valid=111. Then issue rs=0xFFFFFFFF/2/5 → data 0x00000003.
- Issue id=1, commit with kill=1:
  - no result for id 1;
  - a following ADD3 id=2 returns its result normally.
- Fill DEPTH=4 uncommitted entries:
  - ready=0 on the fifth accepted request;
  - commit all → four results in id order.
- Hold x_result_ready_i=0 for 5 cycles: result fields stable; pop on the first ready cycle.
